// File: rtl/regfile_pkg.sv
// regfile_pkg: shared widths and FSM state type for the register-file arbiter
package regfile_pkg;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 16;
  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin picker; last=1 means requester 1 won last time
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);
  always_comb begin
    grant[0] = req[0] & (~req[1] | last);
    grant[1] = req[1] & (~req[0] | ~last);
  end
endmodule

// File: rtl/regfile_arbiter.sv
// regfile_arbiter: round-robin sharing of a 16x16 register file between two requesters
module regfile_arbiter
  import regfile_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] wrAddr0,
  input  logic [ADDR_W-1:0] wrAddr1,
  input  logic [DATA_W-1:0] wrData0,
  input  logic [DATA_W-1:0] wrData1,
  input  logic [ADDR_W-1:0] rdAddrA0,
  input  logic [ADDR_W-1:0] rdAddrB0,
  input  logic [ADDR_W-1:0] rdAddrA1,
  input  logic [ADDR_W-1:0] rdAddrB1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] rdDataA,
  output logic [DATA_W-1:0] rdDataB,
  output logic              rf_write,
  output logic [ADDR_W-1:0] rf_wrAddr,
  output logic [DATA_W-1:0] rf_wrData,
  output logic [ADDR_W-1:0] rf_rdAddrA,
  output logic [ADDR_W-1:0] rf_rdAddrB,
  input  logic [DATA_W-1:0] rf_rdDataA,
  input  logic [DATA_W-1:0] rf_rdDataB
);
  state_t state, nxt;
  logic [1:0] grant;
  logic last, win, we_l, take, live;
  logic [DATA_W-1:0] hold_a, hold_b;
  rr_arb2 u_arb (.req({req1, req0}), .last(last), .grant(grant));
  assign win  = grant[1];
  assign take = (state == IDLE) && (|grant);
  // The register file's own registered read is valid during DONE, so pass it through then
  assign live    = (state == DONE) && !we_l;
  assign rdDataA = live ? rf_rdDataA : hold_a;
  assign rdDataB = live ? rf_rdDataB : hold_b;
  always_comb begin
    nxt = IDLE;
    if (state == IDLE) nxt = take ? ISSUE : IDLE;
    else if (state == ISSUE) nxt = DONE;
  end
  always_ff @(posedge clk) state <= reset ? IDLE : nxt;
  always_ff @(posedge clk) begin
    if (reset) begin
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      done0      <= 1'b0;
      done1      <= 1'b0;
      rf_write   <= 1'b0;
      rf_wrAddr  <= '0;
      rf_wrData  <= '0;
      rf_rdAddrA <= '0;
      rf_rdAddrB <= '0;
      hold_a     <= '0;
      hold_b     <= '0;
      last       <= 1'b1;
      we_l       <= 1'b0;
    end else begin
      rf_write <= 1'b0;
      done0    <= 1'b0;
      done1    <= 1'b0;
      if (take) begin
        last       <= win;
        we_l       <= win ? we1 : we0;
        rf_write   <= win ? we1 : we0;
        rf_wrAddr  <= win ? wrAddr1 : wrAddr0;
        rf_wrData  <= win ? wrData1 : wrData0;
        rf_rdAddrA <= win ? rdAddrA1 : rdAddrA0;
        rf_rdAddrB <= win ? rdAddrB1 : rdAddrB0;
        gnt0       <= !win;
        gnt1       <= win;
      end
      if (state == ISSUE) begin
        done0 <= gnt0;
        done1 <= gnt1;
      end
      if (state == DONE) begin
        gnt0 <= 1'b0;
        gnt1 <= 1'b0;
        if (!we_l) begin
          hold_a <= rf_rdDataA;
          hold_b <= rf_rdDataB;
        end
      end
    end
  end
endmodule

// File: doc/regfile_arbiter.md
REGFILE_ARBITER -- requirements
Module: regfile_arbiter

Interface
REQ-001 The block SHALL have exactly one clock and use a synchronous, active-high reset.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: req0/req1  input  1 each  access request from requester 0 / 1.
REQ-005 Port: we0/we1  input  1 each  1 = write operation, 0 = read operation.
REQ-006 Port: wrAddr0/wrAddr1  input  4 each  write address.
REQ-007 Port: wrData0/wrData1  input  16 each  write data.
REQ-008 Port: rdAddrA0/rdAddrB0/rdAddrA1/rdAddrB1  input  4 each  read addresses for ports A and B.
REQ-009 Port: gnt0/gnt1  output  1 each  requester owns the register file.
REQ-010 Port: done0/done1  output  1 each  one-cycle completion pulse.
REQ-011 Port: rdDataA/rdDataB  output  16 each  read result, shared by both requesters.
REQ-012 Port: rf_write, rf_wrAddr[3:0], rf_wrData[15:0], rf_rdAddrA[3:0], rf_rdAddrB[3:0]  outputs  drive the 16x16 register file.
REQ-013 Port: rf_rdDataA/rf_rdDataB  input  16 each  registered read data from the register file.

Function
REQ-014 FSM states SHALL be IDLE, ISSUE and DONE; every operation takes exactly one cycle in each state (3 cycles per operation).
REQ-015 IDLE: if any reqN=1, the block SHALL select a winner, latch that requester's we, addresses and data, and go to ISSUE; otherwise it stays in IDLE.
REQ-016 Arbitration SHALL be round-robin: with a single request, that requester wins; with both requesting, the requester not served last wins; after reset, requester 0 counts as next-preferred.
REQ-017 ISSUE: rf_* outputs SHALL be registered and present the latched fields; rf_write = latched we for this cycle only.
REQ-018 DONE: rf_write SHALL be 0; doneN SHALL pulse for the winner; for a read, rdDataA/rdDataB SHALL equal rf_rdDataA/rf_rdDataB captured at the end of ISSUE.
REQ-019 After a write, rdDataA/rdDataB SHALL hold their previous values.
REQ-020 gntN SHALL be high in ISSUE and DONE for the winner only; gnt0 and gnt1 SHALL never both be 1.
REQ-021 DONE SHALL always go to IDLE; a req still high in IDLE SHALL be treated as a new request.
REQ-022 Deasserting req during ISSUE/DONE SHALL NOT abort the operation; the latched operation completes and done still pulses.
REQ-023 Input changes after latching SHALL NOT affect the operation in flight.
REQ-024 Outside ISSUE, rf_write SHALL be 0, and rf_* addresses and data SHALL hold their last values.

Reset
REQ-025 reset=1 at a rising edge SHALL force the following:
- state IDLE
- gnt0/gnt1, done0/done1 = 0
- rf_write = 0
- rf_wrAddr, rf_wrData, rf_rdAddrA, rf_rdAddrB = 0
- rdDataA/rdDataB = 0
- round-robin pointer favours requester 0
REQ-026 Reset asserted during ISSUE SHALL NOT prevent the register file from committing that edge's write; no done SHALL be produced for it.
REQ-027 Requests present while reset=1 SHALL be ignored; arbitration resumes on the first cycle with reset=0.

Structure
REQ-028 A shared package regfile_pkg SHALL hold:
- ADDR_W=4
- DATA_W=16
- the FSM state enum (IDLE, ISSUE, DONE)
REQ-029 The two-way round-robin picker SHALL be a sub-module rr_arb2 (inputs: req[1:0], last-winner; output: one-hot grant).

Verification
REQ-030 Single write: req0=1, we0=1, wrAddr0=3, wrData0=16'hBEEF -> gnt0 high 2 cycles, rf_write high 1 cycle with rf_wrAddr=3, done0 pulses 3 cycles after the request.
REQ-031 Read-back: req1=1, we1=0, rdAddrA1=3, rdAddrB1=0 after REQ-030 -> done1 pulses with rdDataA=16'hBEEF.
REQ-032 Contention: req0=req1=1 continuously from reset -> grants alternate 0,1,0,1; gnt0 and gnt1 never overlap.
REQ-033 Mid-operation change: req0 dropped and wrData0 changed to 16'h0000 during ISSUE -> original data is written and done0 still pulses.
REQ-034 Reset in ISSUE of a write to address 5 with 16'h1234 -> all outputs zero next cycle, no done, and a later read of address 5 returns 16'h1234.
REQ-035 Bench SHALL use a behavioural 16x16 register-file model with registered reads suppressed during write, and SHALL check every done against a scoreboard.
